// File: rtl/cmd_stream_arbiter.sv
// rtl/cmd_stream_arbiter.sv - round-robin arbiter sharing one command byte stream between host sources
// A grant is held for one whole command whose length comes from its opcode byte.
module cmd_stream_arbiter #(
  parameter int NUM_SRC            = 2,
  parameter int TRIANGLE_CMD_BYTES = 37,
  parameter int SCENE_CMD_BYTES    = 26,
  localparam int GW                = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [NUM_SRC-1:0]   src_ready,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic [15:0]          cmd_count
);

  if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
    $error("cmd_stream_arbiter: NUM_SRC must be within 2..8");
  end
  if (TRIANGLE_CMD_BYTES < 1 || TRIANGLE_CMD_BYTES > 255) begin : g_bad_tri_len
    $error("cmd_stream_arbiter: TRIANGLE_CMD_BYTES must be within 1..255");
  end
  if (SCENE_CMD_BYTES < 1 || SCENE_CMD_BYTES > 255) begin : g_bad_scene_len
    $error("cmd_stream_arbiter: SCENE_CMD_BYTES must be within 1..255");
  end

  localparam logic [7:0] TRI_LEN   = 8'(TRIANGLE_CMD_BYTES);
  localparam logic [7:0] SCENE_LEN = 8'(SCENE_CMD_BYTES);

  typedef enum logic {
    IDLE    = 1'b0,
    FORWARD = 1'b1
  } state_t;

  state_t         state;
  logic [GW-1:0]  rr_ptr;
  logic [7:0]     bytes_left;
  logic           first_byte;

  logic [7:0]     src_byte [NUM_SRC];
  logic [GW-1:0]  pick;
  logic [GW-1:0]  scan_idx;
  logic           pick_found;
  logic           xfer;
  logic           last_byte;

  function automatic logic [7:0] cmd_len(input logic [7:0] opcode);
    case (opcode)
      8'hA0:   return 8'd2;
      8'hA1:   return TRI_LEN;
      8'hB0:   return SCENE_LEN;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [GW-1:0] next_src(input logic [GW-1:0] v);
    if (v == GW'(NUM_SRC - 1)) return '0;
    else                       return v + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_byte[i] = src_data[8*i +: 8];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    pick       = rr_ptr;
    scan_idx   = rr_ptr;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_idx = GW'((int'(rr_ptr) + i) % NUM_SRC);
      if (!pick_found && src_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  // Zero-latency pass-through of the granted source while forwarding.
  always_comb begin
    src_ready = '0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    if (state == FORWARD) begin
      out_valid           = src_valid[grant_id];
      out_data            = src_byte[grant_id];
      src_ready[grant_id] = out_ready;
    end
  end

  assign xfer      = out_valid && out_ready;
  assign last_byte = xfer && (first_byte ? (cmd_len(out_data) == 8'd1)
                                         : (bytes_left == 8'd1));
  assign busy      = (state == FORWARD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      bytes_left <= 8'd0;
      first_byte <= 1'b1;
      cmd_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id   <= pick;
            first_byte <= 1'b1;
            state      <= FORWARD;
          end
        end
        FORWARD: begin
          if (xfer) begin
            if (first_byte) begin
              bytes_left <= cmd_len(out_data) - 8'd1;
              first_byte <= 1'b0;
            end else begin
              bytes_left <= bytes_left - 8'd1;
            end
            if (last_byte) begin
              state     <= IDLE;
              rr_ptr    <= next_src(grant_id);
              grant_id  <= '0;
              cmd_count <= cmd_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// tb/tb_cmd_stream_arbiter.sv - self-checking bench for cmd_stream_arbiter
// Command-level model predicts outputs every cycle; directed tests pin streams and grants.
module tb_cmd_stream_arbiter;

  localparam int N   = 2;
  localparam int TRI = 37;
  localparam int SCN = 26;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_ready;
  logic [8*N-1:0] src_data;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic [0:0]     grant_id;
  logic           busy;
  logic [15:0]    cmd_count;

  always #5 clk = ~clk;

  cmd_stream_arbiter #(
    .NUM_SRC(N), .TRIANGLE_CMD_BYTES(TRI), .SCENE_CMD_BYTES(SCN)
  ) dut (
    .clk(clk), .rstn(rstn),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .grant_id(grant_id), .busy(busy), .cmd_count(cmd_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source byte queues; a source presents valid whenever it has bytes and is not held.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [N-1:0] hold;
  logic [N-1:0] pop_mask;

  task automatic push(input int s, input logic [7:0] b);
    if (s == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic refresh();
    src_valid[0]   = (q0.size() > 0) && !hold[0];
    src_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
    src_valid[1]   = (q1.size() > 0) && !hold[1];
    src_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_mask[0] && q0.size() > 0) void'(q0.pop_front());
    if (pop_mask[1] && q1.size() > 0) void'(q1.pop_front());
    pop_mask = '0;
    refresh();
  endtask

  // Model: owner of the stream (-1 when idle) and the bytes of the command so far.
  int         m_owner = -1;
  int         m_next  = 0;
  int         m_count = 0;
  int         cyc     = 0;
  logic [7:0] m_cmd[$];
  logic [7:0] q_out[$];
  int         q_cyc[$];
  int         q_grant[$];

  function automatic int len_of(input logic [7:0] op);
    if (op == 8'hA0) return 2;
    if (op == 8'hA1) return TRI;
    if (op == 8'hB0) return SCN;
    return 1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    logic [7:0]   exp_data;
    bit           found;
    int           idx;
    cyc++;
    if (!rstn) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_count", cmd_count, 0);
      m_owner  = -1;
      m_next   = 0;
      m_count  = 0;
      m_cmd.delete();
      pop_mask = '0;
    end else begin
      exp_ready = '0;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      if (m_owner >= 0) begin
        exp_valid          = src_valid[m_owner];
        exp_data           = src_data[8*m_owner +: 8];
        exp_ready[m_owner] = out_ready;
        chk("out_data", out_data, exp_data);
      end
      chk("out_valid", out_valid, exp_valid);
      chk("src_ready", src_ready, exp_ready);
      chk("busy", busy, m_owner >= 0);
      chk("grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
      chk("cmd_count", cmd_count, m_count);
      pop_mask = src_valid & src_ready;
      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_next + k) % N;
          if (!found && src_valid[idx]) begin
            found   = 1;
            m_owner = idx;
            q_grant.push_back(idx);
          end
        end
      end else if (exp_valid && out_ready) begin
        m_cmd.push_back(exp_data);
        q_out.push_back(exp_data);
        q_cyc.push_back(cyc);
        if (m_cmd.size() == len_of(m_cmd[0])) begin
          m_count = (m_count + 1) % 65536;
          m_next  = (m_owner + 1) % N;
          m_owner = -1;
          m_cmd.delete();
        end
      end
    end
  end

  logic [7:0] exp_q[$];
  int         exp_g[$];

  task automatic chk_stream(input string name);
    chk({name, "_len"}, q_out.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_out.size(); i++)
      chk(name, q_out[i], exp_q[i]);
  endtask

  task automatic chk_grants(input string name);
    chk({name, "_len"}, q_grant.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < q_grant.size(); i++)
      chk(name, q_grant[i], exp_g[i]);
  endtask

  task automatic clear_logs();
    q_out.delete();
    q_cyc.delete();
    q_grant.delete();
    exp_q.delete();
    exp_g.delete();
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (q_out.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("stream_progress", q_out.size(), n);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q0.delete();
    q1.delete();
    hold     = '0;
    pop_mask = '0;
    refresh();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    clear_logs();
  endtask

  int c0;

  initial begin
    rstn      = 1'b0;
    out_ready = 1'b1;
    hold      = '0;
    pop_mask  = '0;
    src_valid = '0;
    src_data  = '0;
    tick();
    tick();
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_grant_id", grant_id, 0);
    rstn = 1'b1;
    tick();
    clear_logs();

    // Single source 0xA0 0x05
    push(0, 8'hA0); push(0, 8'h05); refresh();
    c0 = cyc;
    run_until(2, 20);
    exp_q = '{8'hA0, 8'h05}; chk_stream("t1_stream");
    exp_g = '{0};            chk_grants("t1_grants");
    chk("t1_first_latency", q_cyc[0] - c0, 2);
    chk("t1_busy_after", busy, 0);
    chk("t1_cmd_count", cmd_count, 1);

    // Interleave guard: long triangle from src0 while src1 waits
    do_reset();
    push(0, 8'hA1);
    for (int i = 1; i < TRI; i++) push(0, 8'(i + 8'h40));
    push(1, 8'hA0); push(1, 8'h03); refresh();
    run_until(TRI + 2, 100);
    exp_q.push_back(8'hA1);
    for (int i = 1; i < TRI; i++) exp_q.push_back(8'(i + 8'h40));
    exp_q.push_back(8'hA0); exp_q.push_back(8'h03);
    chk_stream("t2_stream");
    exp_g = '{0, 1}; chk_grants("t2_grants");
    chk("t2_bubble", q_cyc[TRI] - q_cyc[TRI-1], 2);
    chk("t2_cmd_count", cmd_count, 2);

    // Round-robin with both sources streaming
    do_reset();
    push(0, 8'hA0); push(0, 8'h11); push(0, 8'hA0); push(0, 8'h12);
    push(1, 8'hA0); push(1, 8'h21); push(1, 8'hA0); push(1, 8'h22);
    refresh();
    run_until(8, 40);
    exp_q = '{8'hA0, 8'h11, 8'hA0, 8'h21, 8'hA0, 8'h12, 8'hA0, 8'h22};
    chk_stream("t3_stream");
    exp_g = '{0, 1, 0, 1}; chk_grants("t3_grants");
    chk("t3_cmd_count", cmd_count, 4);

    // Unknown opcode is a one-byte command
    do_reset();
    push(1, 8'h55); push(1, 8'hB0);
    for (int i = 1; i < SCN; i++) push(1, 8'(i));
    refresh();
    run_until(SCN + 1, 80);
    exp_q.push_back(8'h55); exp_q.push_back(8'hB0);
    for (int i = 1; i < SCN; i++) exp_q.push_back(8'(i));
    chk_stream("t4_stream");
    exp_g = '{1, 1}; chk_grants("t4_grants");
    chk("t4_bubble", q_cyc[1] - q_cyc[0], 2);
    chk("t4_cmd_count", cmd_count, 2);

    // Stall: granted source drops valid mid-command, other source must wait
    do_reset();
    push(0, 8'hA0); push(0, 8'h77); push(1, 8'hA0); push(1, 8'h88); refresh();
    run_until(1, 10);
    hold[0] = 1'b1; refresh();
    repeat (5) tick();
    chk("t5_busy_stalled", busy, 1);
    chk("t5_grant_stalled", grant_id, 0);
    chk("t5_src1_ready", src_ready[1], 0);
    hold[0] = 1'b0; refresh();
    run_until(4, 20);
    exp_q = '{8'hA0, 8'h77, 8'hA0, 8'h88}; chk_stream("t5_stream");
    exp_g = '{0, 1};                       chk_grants("t5_grants");

    // Backpressure: out_ready toggles during a scene command
    do_reset();
    push(0, 8'hB0);
    for (int i = 1; i < SCN; i++) push(0, 8'(8'h80 + i));
    refresh();
    begin
      int c;
      c = 0;
      while (q_out.size() < SCN && c < 200) begin
        out_ready = ~out_ready;
        tick();
        c++;
      end
    end
    out_ready = 1'b1;
    tick();
    exp_q.push_back(8'hB0);
    for (int i = 1; i < SCN; i++) exp_q.push_back(8'(8'h80 + i));
    chk_stream("t6_stream");
    chk("t6_cmd_count", cmd_count, 1);
    chk("t6_busy_after", busy, 0);

    // Reset mid-command, then a fresh command from src1
    clear_logs();
    push(0, 8'hA1);
    for (int i = 1; i < TRI; i++) push(0, 8'(i));
    refresh();
    run_until(10, 30);
    rstn = 1'b0;
    #1;
    chk("t7_rst_out_valid", out_valid, 0);
    chk("t7_rst_out_data", out_data, 8'h00);
    chk("t7_rst_src_ready", src_ready, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_grant_id", grant_id, 0);
    chk("t7_rst_cmd_count", cmd_count, 0);
    q0.delete(); q1.delete(); pop_mask = '0; refresh();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    clear_logs();
    push(1, 8'hA0); push(1, 8'h01); refresh();
    run_until(2, 20);
    tick();
    exp_q = '{8'hA0, 8'h01}; chk_stream("t7_stream");
    exp_g = '{1};            chk_grants("t7_grants");
    chk("t7_cmd_count", cmd_count, 1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_stream_arbiter.md
Name: cmd_stream_arbiter

Overview:
- Shares the single command byte stream into the command decoder between NUM_SRC host byte sources (e.g. SPI and UART front-ends).
- Grants one source at a time and holds the grant for exactly one complete command, so bytes from different hosts never interleave mid-command.
- Decodes the opcode of each granted command to know its length; releases the grant after the last byte; arbitrates round-robin.
- Sits between the host interface receivers and the command decoder's cmd_in port.

Parameters:
- NUM_SRC, 2, number of requesting byte sources (2..8).
- TRIANGLE_CMD_BYTES, 37, total bytes of opcode 0xA1 including opcode; integrator sets to 1 + triangle payload bits/8.
- SCENE_CMD_BYTES, 26, total bytes of opcode 0xB0 including opcode; integrator sets to 1 + scene payload bits/8.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_ready  out  NUM_SRC  per-source byte ready.
- src_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i].
- out_valid  out  1  byte valid toward the command decoder.
- out_ready  in  1  command decoder ready.
- out_data  out  8  forwarded byte.
- grant_id  out  $clog2(NUM_SRC) (min 1)  currently granted source; 0 when idle.
- busy  out  1  high while a command is being forwarded (state FORWARD).
- cmd_count  out  16  number of completed commands; wraps 0xFFFF->0.

Behaviour:
- Reset (async, any time, including mid-command): state IDLE, rr_ptr=0, grant_id=0, bytes_left=0, first_byte=1, cmd_count=0; src_ready=0, out_valid=0, out_data=0, busy=0.
- A partially forwarded command is abandoned on reset. The downstream decoder is reset by the same rstn.
- Opcode lengths (total bytes):
  - 0xA0 -> 2.
  - 0xA1 -> TRIANGLE_CMD_BYTES.
  - 0xB0 -> SCENE_CMD_BYTES.
  - any other value -> 1; the byte is forwarded unchanged and the decoder discards it.
- IDLE:
  - out_valid=0, all src_ready=0.
  - If any src_valid is high, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Register that index into grant_id, set first_byte=1, go to FORWARD.
  - No byte is consumed in the arbitration cycle, so grant latency is 1 cycle after a request is first seen.
- FORWARD:
  - Pure combinational pass-through of the granted source: out_valid=src_valid[g], out_data=src_data[g], src_ready[g]=out_ready; other src_ready=0.
  - Zero added latency; no buffering.
  - Transfer = out_valid && out_ready.
  - On a transfer with first_byte=1: bytes_left = length(out_data) - 1, first_byte=0.
  - On a transfer with first_byte=0: bytes_left decrements.
  - The last byte is a transfer where (first_byte && length==1) or (!first_byte && bytes_left==1). On it:
    - state -> IDLE;
    - rr_ptr = grant_id+1 modulo NUM_SRC;
    - cmd_count increments.
- Bubble: exactly one idle cycle between consecutive commands, even from the same source.
- Stall: the granted source dropping src_valid mid-command holds the grant indefinitely. There is no timeout, and other sources wait.
- Non-granted sources: src_valid is ignored and their data is never forwarded.
- Fairness: with all sources continuously requesting, grants rotate 0,1,...,NUM_SRC-1,0.
- Width rules: bytes_left is 8 bits; lengths above 255 are illegal parameter values (elaboration assertion).

Test Plan:
- Single source, 0xA0 0x05 from src0 -> grant_id=0 one cycle after src_valid; out_data 0xA0 then 0x05; cmd_count=1; busy falls the cycle after byte 2.
- Interleave guard: src0 sends 0xA1 plus 36 payload bytes while src1 holds valid with 0xA0 0x03 -> out stream is all 37 src0 bytes, then one bubble, then 0xA0 0x03; src1_ready stays 0 throughout src0's command.
- Round-robin: both sources stream back-to-back 0xA0 xx commands -> grant sequence 0,1,0,1; cmd_count=4 after four commands.
- Unknown opcode: src1 sends 0x55 then 0xB0 plus 25 bytes -> 0x55 forwarded as a 1-byte command (cmd_count +1), then the 26-byte command granted separately.
- Backpressure: out_ready toggles 1,0,1,0 during a 0xB0 command -> each byte is held stable while out_ready=0; no byte is lost or duplicated; byte count is 26.
- Reset mid-command: assert rstn low after byte 10 of 0xA1 -> all outputs 0 immediately (async). After release, a fresh 0xA0 0x01 from src1 forwards correctly and cmd_count=1.
